// File: rtl/gig_eth_tx_frame_fifo.sv
// Store-and-forward transmit frame buffer ahead of the gigabit MAC TX stage.
// A frame is committed when its last byte is written. Committed frames are then replayed whole, one byte per cycle.
module gig_eth_tx_frame_fifo #(
    parameter int ADDR_W = 12,
    parameter int FCNT_W = 8
) (
    input  logic              tx_clk,
    input  logic              reset_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              wr_eof,
    input  logic              wr_drop,
    output logic              wr_full,
    output logic              drop_pulse,
    output logic [FCNT_W-1:0] frame_count,
    output logic [7:0]        mac_tx_data,
    output logic              mac_tx_dvld,
    output logic              mac_tx_underrun,
    input  logic              mac_tx_ack
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ACK, SEND, GAP} state_t;

    state_t state, state_nxt;

    logic [8:0]       mem [0:(2**ADDR_W)-1];
    logic [8:0]       rd_word_p1;
    logic             out_eof_p2;
    logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic             bad;
    logic             wr_accept, commit, discard, mark_bad;
    logic             rd_en, load_out, clear_out, gap_done;

    assign wr_full         = (wr_ptr - rd_ptr) == DEPTH;
    assign mac_tx_underrun = 1'b0;

    // A frame is refused when it would not fit or when the commit counter is saturated.
    always_comb begin
        wr_accept = 1'b0;
        commit    = 1'b0;
        discard   = 1'b0;
        mark_bad  = 1'b0;
        if (wr_drop) begin
            discard = 1'b1;
        end else if (wr_en) begin
            if (bad || wr_full || (wr_eof && (frame_count == '1))) begin
                discard  = wr_eof;
                mark_bad = !wr_eof;
            end else begin
                wr_accept = 1'b1;
                commit    = wr_eof;
            end
        end
    end

    // p0 -> p1: storage write and synchronous read into the prefetch word
    always_ff @(posedge tx_clk) begin
        if (wr_accept)
            mem[wr_ptr[ADDR_W-1:0]] <= {wr_eof, wr_data};
        if (rd_en)
            rd_word_p1 <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            bad         <= 1'b0;
            drop_pulse  <= 1'b0;
            frame_count <= '0;
        end else begin
            drop_pulse <= discard;
            if (discard)
                wr_ptr <= commit_ptr;
            else if (wr_accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (commit)
                commit_ptr <= wr_ptr + PTR_W'(1);
            if (discard)
                bad <= 1'b0;
            else if (mark_bad)
                bad <= 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({commit, gap_done})
                2'b10:   frame_count <= frame_count + FCNT_W'(1);
                2'b01:   frame_count <= frame_count - FCNT_W'(1);
                default: frame_count <= frame_count;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The next read is issued only while the byte being loaded is not the last one,
    // so the prefetch word always holds the following byte and reads stop at the frame end.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        load_out  = 1'b0;
        clear_out = 1'b0;
        gap_done  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_count != '0) begin
                    rd_en     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                load_out  = 1'b1;
                rd_en     = !rd_word_p1[8];
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (mac_tx_ack) begin
                    if (out_eof_p2) begin
                        clear_out = 1'b1;
                        state_nxt = GAP;
                    end else begin
                        load_out  = 1'b1;
                        rd_en     = !rd_word_p1[8];
                        state_nxt = SEND;
                    end
                end
            end
            SEND: begin
                if (out_eof_p2) begin
                    clear_out = 1'b1;
                    state_nxt = GAP;
                end else begin
                    load_out = 1'b1;
                    rd_en    = !rd_word_p1[8];
                end
            end
            GAP: begin
                gap_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p1 -> p2: registered MAC client outputs
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_tx_data <= 8'h00;
            mac_tx_dvld <= 1'b0;
            out_eof_p2  <= 1'b0;
        end else if (clear_out) begin
            mac_tx_data <= 8'h00;
            mac_tx_dvld <= 1'b0;
            out_eof_p2  <= 1'b0;
        end else if (load_out) begin
            mac_tx_data <= rd_word_p1[7:0];
            mac_tx_dvld <= 1'b1;
            out_eof_p2  <= rd_word_p1[8];
        end
    end

endmodule

// File: tb/tb_gig_eth_tx_frame_fifo.sv
// Scoreboard bench for gig_eth_tx_frame_fifo: a writer pushes accepted frames and a MAC model pops and checks them.
module tb_gig_eth_tx_frame_fifo;

    localparam int AW    = 6;
    localparam int FW    = 3;
    localparam int DEPTH = 64;
    localparam int FMAX  = 7;

    logic          tx_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0, wr_eof = 1'b0, wr_drop = 1'b0;
    logic          wr_full, drop_pulse;
    logic [FW-1:0] frame_count;
    logic [7:0]    mac_tx_data;
    logic          mac_tx_dvld, mac_tx_underrun;
    logic          mac_tx_ack = 1'b0;

    gig_eth_tx_frame_fifo #(.ADDR_W(AW), .FCNT_W(FW)) dut (
        .tx_clk(tx_clk), .reset_n(reset_n),
        .wr_data(wr_data), .wr_en(wr_en), .wr_eof(wr_eof), .wr_drop(wr_drop),
        .wr_full(wr_full), .drop_pulse(drop_pulse), .frame_count(frame_count),
        .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld),
        .mac_tx_underrun(mac_tx_underrun), .mac_tx_ack(mac_tx_ack)
    );

    always #5 tx_clk = ~tx_clk;

    int checks = 0, errors = 0;
    logic [7:0] sb_data[$];
    int         sb_len[$];
    int  mst = 0, cur_len = 0, idx = 0, ack_wait = 0, ack_dly = 0;
    bit  mon_busy = 0, ack_hold = 0;
    int  ack_fixed = -1;
    int  frames_done = 0, frames_exp = 0, drop_seen = 0, drop_exp = 0;
    logic [7:0] first_b, exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // MAC model and scoreboard monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge tx_clk);
            mac_tx_ack = 1'b0;
            if (!reset_n) begin
                mst = 0;
                mon_busy = 0;
                continue;
            end
            if (drop_pulse) drop_seen++;
            case (mst)
                0: if (mac_tx_dvld) begin
                    chk("underrun", 32'(mac_tx_underrun), 0);
                    chk("frame_expected", 32'(sb_len.size() != 0), 1);
                    if (sb_len.size() == 0) begin
                        mac_tx_ack = 1'b1;
                        mst = 3;
                    end else begin
                        cur_len = sb_len.pop_front();
                        first_b = sb_data.pop_front();
                        mon_busy = 1;
                        chk("first_byte", 32'(mac_tx_data), 32'(first_b));
                        ack_dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 4));
                        if (!ack_hold && ack_dly == 0) begin
                            mac_tx_ack = 1'b1;
                            idx = 1;
                            mst = 2;
                        end else begin
                            ack_wait = 1;
                            mst = 1;
                        end
                    end
                end
                1: begin
                    chk("held_dvld", 32'(mac_tx_dvld), 1);
                    chk("held_data", 32'(mac_tx_data), 32'(first_b));
                    if (!ack_hold && ack_wait >= ack_dly) begin
                        mac_tx_ack = 1'b1;
                        idx = 1;
                        mst = 2;
                    end else begin
                        ack_wait++;
                    end
                end
                2: if (idx < cur_len) begin
                    exp_b = sb_data.pop_front();
                    chk("send_dvld", 32'(mac_tx_dvld), 1);
                    chk("send_data", 32'(mac_tx_data), 32'(exp_b));
                    idx++;
                    if ($urandom_range(0, 3) == 0) mac_tx_ack = 1'b1;
                end else begin
                    chk("gap_dvld", 32'(mac_tx_dvld), 0);
                    chk("gap_data", 32'(mac_tx_data), 0);
                    mon_busy = 0;
                    frames_done++;
                    mst = 0;
                end
                default: begin
                    if (!mac_tx_dvld) mst = 0;
                    else mac_tx_ack = 1'b1;
                end
            endcase
        end
    end

    // Reference model: a frame is kept only if it fits beside everything still queued or in flight.
    function automatic bit model_accepts(input int len);
        int pending, used;
        pending = sb_len.size() + (mon_busy ? 1 : 0);
        used    = sb_data.size() + (mon_busy ? cur_len : 0);
        return (pending < FMAX) && (len <= DEPTH - used);
    endfunction

    task automatic drive(input logic en, input logic [7:0] d, input logic eof, input logic drop);
        wr_en = en; wr_data = d; wr_eof = eof; wr_drop = drop;
        @(negedge tx_clk);
    endtask

    task automatic send_frame(input int len, input int base, input int drop_at,
                              input bit drop_with_byte, input bit gaps);
        logic [7:0] b[$];
        bit acc = 0, dropped = 0;
        for (int i = 0; i < len; i++)
            b.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 4) == 0) drive(1'b0, 8'h00, 1'b0, 1'b0);
            if (i == drop_at) begin
                drive(drop_with_byte, b[i], i == len - 1, 1'b1);
                dropped = 1;
                break;
            end
            if (i == len - 1) begin
                acc = model_accepts(len);
                if (acc) begin
                    foreach (b[k]) sb_data.push_back(b[k]);
                    sb_len.push_back(len);
                    frames_exp++;
                end
            end
            drive(1'b1, b[i], i == len - 1, 1'b0);
        end
        wr_en = 1'b0; wr_eof = 1'b0; wr_drop = 1'b0;
        if (dropped || !acc) begin
            drop_exp++;
            chk("drop_pulse_set", 32'(drop_pulse), 1);
        end else begin
            chk("drop_pulse_clear", 32'(drop_pulse), 0);
        end
    endtask

    task automatic wait_pending(input int maxp, input int budget);
        for (int c = 0; c < budget && (sb_len.size() + (mon_busy ? 1 : 0)) > maxp; c++)
            @(negedge tx_clk);
        chk("pending_within_budget", 32'((sb_len.size() + (mon_busy ? 1 : 0)) <= maxp), 1);
    endtask

    task automatic drain();
        wait_pending(0, 3000);
        repeat (3) @(negedge tx_clk);
        chk("fcnt_drained", 32'(frame_count), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int len, dat, lost;
        repeat (2) @(negedge tx_clk);
        chk("rst_dvld", 32'(mac_tx_dvld), 0);
        chk("rst_data", 32'(mac_tx_data), 0);
        chk("rst_full", 32'(wr_full), 0);
        chk("rst_drop", 32'(drop_pulse), 0);
        chk("rst_fcnt", 32'(frame_count), 0);
        chk("rst_underrun", 32'(mac_tx_underrun), 0);
        reset_n = 1'b1;
        @(negedge tx_clk);

        // 60-byte frame, late acknowledge
        ack_fixed = 9;
        send_frame(60, 0, -1, 0, 0);
        chk("fcnt_after_commit", 32'(frame_count), 1);
        drain();

        // three frames back-to-back, immediate acknowledge
        ack_fixed = 0;
        send_frame(20, 8'h10, -1, 0, 0);
        send_frame(20, 8'h80, -1, 0, 0);
        send_frame(20, 8'hc0, -1, 0, 0);
        drain();

        // single-byte frame
        ack_fixed = 3;
        send_frame(1, 8'ha5, -1, 0, 0);
        drain();
        ack_fixed = -1;

        // overflow with no reads in progress
        acc = 1;
        for (int i = 0; i < 70; i++) begin
            if (i == 69) acc = model_accepts(70);
            drive(1'b1, 8'(i), i == 69, 1'b0);
            if (i == 62) chk("full_at_63", 32'(wr_full), 0);
            if (i == 63) chk("full_at_64", 32'(wr_full), 1);
        end
        wr_en = 1'b0; wr_eof = 1'b0;
        if (!acc) drop_exp++;
        chk("ovf_drop_pulse", 32'(drop_pulse), 32'(!acc));
        @(negedge tx_clk);
        chk("ovf_drop_pulse_end", 32'(drop_pulse), 0);
        chk("ovf_fcnt", 32'(frame_count), 0);
        chk("ovf_full_cleared", 32'(wr_full), 0);
        send_frame(10, 8'h20, -1, 0, 0);
        drain();

        // writer abort after 20 bytes
        send_frame(21, 0, 20, 0, 0);
        @(negedge tx_clk);
        chk("abort_pulse_end", 32'(drop_pulse), 0);
        send_frame(50, 8'h60, -1, 0, 0);
        drain();

        // commit counter saturation
        ack_hold = 1;
        for (int i = 0; i < FMAX; i++) send_frame(1, 8'hd0 + i, -1, 0, 0);
        chk("fcnt_at_max", 32'(frame_count), FMAX);
        send_frame(1, 8'h77, -1, 0, 0);
        chk("fcnt_still_max", 32'(frame_count), FMAX);
        ack_hold = 0;
        drain();

        // randomized traffic with aborts and idle cycles
        for (int f = 0; f < 40; f++) begin
            wait_pending(1, 3000);
            len = int'($urandom_range(1, 20));
            dat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            send_frame(len, -1, dat, bit'($urandom_range(0, 1)), 1);
        end
        drain();
        chk("drop_count", 32'(drop_seen), 32'(drop_exp));

        // reset in the middle of a transfer
        ack_fixed = 0;
        send_frame(40, 0, -1, 0, 0);
        for (int c = 0; c < 200 && !(mst == 2 && idx == 31); c++) begin
            @(negedge tx_clk);
            #1;
        end
        chk("reached_byte_30", 32'(mst == 2 && idx == 31), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_dvld", 32'(mac_tx_dvld), 0);
        chk("midrst_data", 32'(mac_tx_data), 0);
        chk("midrst_fcnt", 32'(frame_count), 0);
        lost = sb_len.size() + (mon_busy ? 1 : 0);
        frames_exp -= lost;
        sb_data.delete();
        sb_len.delete();
        repeat (2) @(posedge tx_clk);
        #2;
        reset_n = 1'b1;
        @(negedge tx_clk);
        ack_fixed = -1;
        send_frame(12, 8'h30, -1, 0, 0);
        drain();

        chk("frames_done", 32'(frames_done), 32'(frames_exp));
        chk("drop_total", 32'(drop_seen), 32'(drop_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
